// File: rtl/candidate_dispatch_if.sv
// Candidate stream from the dispatcher to the refinement stage.
// The dispatcher drives the item fields; the consumer returns out_ready.
interface candidate_dispatch_if #(
    parameter int ANGLE_W = 24
);
    logic                 out_valid;
    logic                 out_ready;
    logic [ANGLE_W/2-1:0] theta;
    logic [ANGLE_W/2-1:0] phi;
    logic [3:0]           out_rank;
    logic                 out_last;

    modport master (
        output out_valid,
        output theta,
        output phi,
        output out_rank,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  theta,
        input  phi,
        input  out_rank,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/candidate_dispatch.sv
// Snapshots the sorted top-N candidate buffer and streams the best compare_num
// entries, highest slot first, over a valid/ready interface.
module candidate_dispatch #(
    parameter int ANGLE_W = 24,
    parameter int SLOTS   = 10
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       buf_load,
    input  logic [SLOTS*ANGLE_W-1:0]   candidate_angle_buffer,
    input  logic [3:0]                 compare_num,
    candidate_dispatch_if.master       dsp,
    output logic                       busy,
    output logic                       done,
    output logic                       overrun
);
    localparam int HALF_W = ANGLE_W / 2;
    localparam int PTR_W  = (SLOTS > 1) ? $clog2(SLOTS) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, SEND, DONE} state_t;

    state_t                     state, state_nx;
    logic [SLOTS*ANGLE_W-1:0]   shadow, shadow_nx;
    logic [3:0]                 n_reg, n_nx;
    logic [PTR_W-1:0]           ptr, ptr_nx;
    logic                       valid_nx, last_nx, busy_nx, done_nx, overrun_nx;
    logic [HALF_W-1:0]          theta_nx, phi_nx;
    logic [3:0]                 rank_nx;
    logic [3:0]                 n_clamped;
    logic                       present_item;
    logic [ANGLE_W-1:0]         slot_arr [SLOTS];

    for (genvar k = 0; k < SLOTS; k++) begin : g_slot
        assign slot_arr[k] = shadow[ANGLE_W*k +: ANGLE_W];
    end

    assign n_clamped = (compare_num > 4'(SLOTS)) ? 4'(SLOTS) : compare_num;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            shadow        <= '0;
            n_reg         <= '0;
            ptr           <= '0;
            dsp.out_valid <= 1'b0;
            dsp.theta     <= '0;
            dsp.phi       <= '0;
            dsp.out_rank  <= '0;
            dsp.out_last  <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            state         <= state_nx;
            shadow        <= shadow_nx;
            n_reg         <= n_nx;
            ptr           <= ptr_nx;
            dsp.out_valid <= valid_nx;
            dsp.theta     <= theta_nx;
            dsp.phi       <= phi_nx;
            dsp.out_rank  <= rank_nx;
            dsp.out_last  <= last_nx;
            busy          <= busy_nx;
            done          <= done_nx;
            overrun       <= overrun_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        shadow_nx    = shadow;
        n_nx         = n_reg;
        ptr_nx       = ptr;
        valid_nx     = dsp.out_valid;
        theta_nx     = dsp.theta;
        phi_nx       = dsp.phi;
        rank_nx      = dsp.out_rank;
        last_nx      = dsp.out_last;
        busy_nx      = busy;
        done_nx      = 1'b0;
        overrun_nx   = 1'b0;
        present_item = 1'b0;

        unique case (state)
            IDLE, DONE: begin
                // DONE behaves like IDLE so a load can follow a finished dispatch immediately.
                state_nx = IDLE;
                busy_nx  = 1'b0;
                if (buf_load) begin
                    shadow_nx = candidate_angle_buffer;
                    n_nx      = n_clamped;
                    ptr_nx    = PTR_W'(SLOTS - 1);
                    rank_nx   = '0;
                    if (n_clamped == 4'd0) begin
                        state_nx = DONE;
                        done_nx  = 1'b1;
                    end else begin
                        state_nx = LOAD;
                        busy_nx  = 1'b1;
                    end
                end
            end

            LOAD: begin
                overrun_nx   = buf_load;
                valid_nx     = 1'b1;
                rank_nx      = '0;
                last_nx      = (n_reg == 4'd1);
                present_item = 1'b1;
                state_nx     = SEND;
            end

            SEND: begin
                overrun_nx = buf_load;
                if (dsp.out_valid && dsp.out_ready) begin
                    if (dsp.out_last) begin
                        valid_nx = 1'b0;
                        busy_nx  = 1'b0;
                        done_nx  = 1'b1;
                        state_nx = DONE;
                    end else begin
                        ptr_nx       = ptr - 1'b1;
                        rank_nx      = dsp.out_rank + 4'd1;
                        last_nx      = (rank_nx == n_reg - 4'd1);
                        present_item = 1'b1;
                    end
                end
            end

            default: state_nx = IDLE;
        endcase

        // Theta sits in the upper half of each slot, phi in the lower half.
        if (present_item) begin
            theta_nx = slot_arr[ptr_nx][ANGLE_W-1:HALF_W];
            phi_nx   = slot_arr[ptr_nx][HALF_W-1:0];
        end
    end
endmodule
